// File: rtl/eth_frame_gen_if.sv
// Frame stream carrying 64-bit beats with byte enables, per-byte error flags and a port tag.
interface eth_frame_gen_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 3
);
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] keep;
  logic                    last;
  logic [DATA_WIDTH/8-1:0] user;
  logic [ID_WIDTH-1:0]     id;
  logic                    valid;
  logic                    ready;

  modport master (
    output data, keep, last, user, id, valid,
    input  ready
  );

  modport slave (
    input  data, keep, last, user, id, valid,
    output ready
  );
endinterface

// File: rtl/eth_frame_gen.sv
// Test-frame source: emits a programmable burst of Ethernet frames whose payload carries a
// sequence number and a deterministic byte pattern, so a downstream checker needs no storage.
module eth_frame_gen #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 3,
  parameter int unsigned MIN_LEN    = 60,
  parameter int unsigned MAX_LEN    = 9600
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic [15:0]         cfg_len,
  input  logic [31:0]         cfg_count,
  input  logic [7:0]          cfg_gap,
  input  logic [ID_WIDTH-1:0] cfg_id,
  input  logic                cfg_err,
  eth_frame_gen_if.master     m,
  output logic                busy,
  output logic                done,
  output logic [31:0]         frames_sent
);

  localparam int unsigned KeepW  = DATA_WIDTH / 8;
  localparam logic [15:0] MinLen = 16'(MIN_LEN);
  localparam logic [15:0] MaxLen = 16'(MAX_LEN);

  if (DATA_WIDTH != 64) begin : g_bad_width
    $error("eth_frame_gen: only DATA_WIDTH = 64 is supported");
  end

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KeepW-1:0]      keep;
    logic                  last;
    logic [KeepW-1:0]      user;
  } beat_t;

  state_e             state_q;
  logic [15:0]        len_q;
  logic [15:0]        last_idx_q;
  logic [31:0]        count_q;
  logic [7:0]         gap_q;
  logic               err_q;
  logic [31:0]        seq_q;
  logic [15:0]        beat_idx_q;
  logic [7:0]         gap_cnt_q;
  logic               stop_q;

  logic [15:0]        len_clamp;
  logic [15:0]        last_idx_clamp;
  logic [31:0]        frames_inc;
  logic               burst_end;
  beat_t              beat_start;
  beat_t              beat_cont;
  beat_t              beat_new;

  // Build one beat of a frame: byte k of the frame lands in lane k%8 of beat k/8.
  function automatic beat_t make_beat(input logic [31:0] seq, input logic [15:0] len,
                                      input logic [15:0] idx, input logic [15:0] last_idx,
                                      input logic err);
    beat_t       b;
    logic [15:0] k;
    logic [7:0]  bv;
    b = '0;
    b.last = (idx == last_idx);
    for (int i = 0; i < int'(KeepW); i++) begin
      k  = {idx[12:0], 3'b000} + 16'(i);
      bv = 8'h00;
      if (k < len) begin
        b.keep[i] = 1'b1;
        case (k)
          16'd0:   bv = seq[7:0];
          16'd1:   bv = seq[15:8];
          16'd2:   bv = seq[23:16];
          16'd3:   bv = seq[31:24];
          16'd4:   bv = len[7:0];
          16'd5:   bv = len[15:8];
          16'd6:   bv = 8'hA5;
          16'd7:   bv = 8'h5A;
          default: bv = k[7:0] ^ seq[7:0];
        endcase
      end
      b.data[8*i +: 8] = bv;
    end
    if (b.last && err) b.user = '1;
    return b;
  endfunction

  // Length clamp, burst-end decision and the candidate next beats.
  always_comb begin
    len_clamp = cfg_len;
    if (cfg_len < MinLen) len_clamp = MinLen;
    else if (cfg_len > MaxLen) len_clamp = MaxLen;
    last_idx_clamp = (len_clamp - 16'd1) >> 3;
    frames_inc = (frames_sent == 32'hFFFF_FFFF) ? frames_sent : frames_sent + 32'd1;
    // A stop arriving on the final handshake still ends the burst there.
    burst_end  = stop_q || stop || ((count_q != 32'd0) && (frames_inc >= count_q));
    beat_start = make_beat(32'd0, len_clamp, 16'd0, last_idx_clamp, cfg_err);
    beat_cont  = make_beat(seq_q, len_q, beat_idx_q + 16'd1, last_idx_q, err_q);
    beat_new   = make_beat((state_q == StGap) ? seq_q : seq_q + 32'd1, len_q, 16'd0,
                           last_idx_q, err_q);
  end

  // Burst FSM with registered stream outputs; outputs only change on a handshake or state move.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      last_idx_q  <= '0;
      count_q     <= '0;
      gap_q       <= '0;
      err_q       <= 1'b0;
      seq_q       <= '0;
      beat_idx_q  <= '0;
      gap_cnt_q   <= '0;
      stop_q      <= 1'b0;
      m.data      <= '0;
      m.keep      <= '0;
      m.last      <= 1'b0;
      m.user      <= '0;
      m.id        <= '0;
      m.valid     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frames_sent <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_q       <= len_clamp;
            last_idx_q  <= last_idx_clamp;
            count_q     <= cfg_count;
            gap_q       <= cfg_gap;
            err_q       <= cfg_err;
            m.id        <= cfg_id;
            seq_q       <= '0;
            frames_sent <= '0;
            beat_idx_q  <= '0;
            stop_q      <= 1'b0;
            busy        <= 1'b1;
            {m.data, m.keep, m.last, m.user} <= beat_start;
            m.valid     <= 1'b1;
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (stop) stop_q <= 1'b1;
          if (m.valid && m.ready) begin
            if (!m.last) begin
              beat_idx_q <= beat_idx_q + 16'd1;
              {m.data, m.keep, m.last, m.user} <= beat_cont;
            end else begin
              frames_sent <= frames_inc;
              seq_q       <= seq_q + 32'd1;
              beat_idx_q  <= '0;
              if (burst_end) begin
                {m.data, m.keep, m.last, m.user} <= '0;
                m.valid <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
                stop_q  <= 1'b0;
                state_q <= StIdle;
              end else if (gap_q != 8'd0) begin
                {m.data, m.keep, m.last, m.user} <= '0;
                m.valid   <= 1'b0;
                gap_cnt_q <= gap_q;
                state_q   <= StGap;
              end else begin
                {m.data, m.keep, m.last, m.user} <= beat_new;
              end
            end
          end
        end
        StGap: begin
          if (stop) stop_q <= 1'b1;
          if (gap_cnt_q == 8'd1) begin
            if (stop_q || stop) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              stop_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              {m.data, m.keep, m.last, m.user} <= beat_new;
              m.valid <= 1'b1;
              state_q <= StSend;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_gen.sv
// Directed bench for eth_frame_gen: a negedge monitor rebuilds every accepted beat from the frame
// layout and checks it, plus stall stability, intra-frame continuity and inter-frame gaps.
module tb_eth_frame_gen;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic [15:0] cfg_len;
  logic [31:0] cfg_count;
  logic [7:0]  cfg_gap;
  logic [2:0]  cfg_id;
  logic        cfg_err;
  logic        busy;
  logic        done;
  logic [31:0] frames_sent;

  int n_checks = 0;
  int n_fail   = 0;

  eth_frame_gen_if #(.DATA_WIDTH(64), .ID_WIDTH(3)) m_if ();

  eth_frame_gen dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .cfg_len     (cfg_len),
    .cfg_count   (cfg_count),
    .cfg_gap     (cfg_gap),
    .cfg_id      (cfg_id),
    .cfg_err     (cfg_err),
    .m           (m_if),
    .busy        (busy),
    .done        (done),
    .frames_sent (frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] clamp_len(input logic [15:0] l);
    if (l < 16'd60) return 16'd60;
    if (l > 16'd9600) return 16'd9600;
    return l;
  endfunction

  // Monitor state
  logic [15:0] exp_len;
  logic        exp_err;
  logic [2:0]  exp_id;
  logic [31:0] exp_seq;
  int          off;
  int          frames_rx;
  bit          in_frame;
  bit          have_prev;
  int          idle_run;
  int          gap_min;
  int          gap_max;
  bit          held;
  logic [63:0] held_data;
  logic [7:0]  held_keep;
  logic        held_last;
  logic [7:0]  held_user;

  always @(negedge clk) begin
    logic [63:0] e_data;
    logic [7:0]  e_keep;
    logic        e_last;
    int          k;
    if (!reset_n) begin
      in_frame = 1'b0;
      held     = 1'b0;
      off      = 0;
    end else begin
      if (start && !busy) begin
        exp_len   = clamp_len(cfg_len);
        exp_err   = cfg_err;
        exp_id    = cfg_id;
        exp_seq   = 32'd0;
        off       = 0;
        frames_rx = 0;
        in_frame  = 1'b0;
        have_prev = 1'b0;
        idle_run  = 0;
        gap_min   = 1000;
        gap_max   = 0;
      end
      if (held) begin
        check("stall_valid", 64'(m_if.valid), 64'd1);
        check("stall_data", m_if.data, held_data);
        check("stall_keep", 64'(m_if.keep), 64'(held_keep));
        check("stall_last", 64'(m_if.last), 64'(held_last));
        check("stall_user", 64'(m_if.user), 64'(held_user));
      end
      if (in_frame && !held) check("valid_in_frame", 64'(m_if.valid), 64'd1);
      if (!m_if.valid) begin
        idle_run++;
      end else if (!in_frame) begin
        in_frame = 1'b1;
        if (have_prev) begin
          if (idle_run < gap_min) gap_min = idle_run;
          if (idle_run > gap_max) gap_max = idle_run;
        end
      end
      if (m_if.valid && m_if.ready) begin
        e_data = '0;
        e_keep = '0;
        for (int i = 0; i < 8; i++) begin
          k = off + i;
          if (k < int'(exp_len)) begin
            e_keep[i] = 1'b1;
            if (k < 4) e_data[8*i +: 8] = 8'(exp_seq >> (8 * k));
            else if (k == 4) e_data[8*i +: 8] = exp_len[7:0];
            else if (k == 5) e_data[8*i +: 8] = exp_len[15:8];
            else if (k == 6) e_data[8*i +: 8] = 8'hA5;
            else if (k == 7) e_data[8*i +: 8] = 8'h5A;
            else e_data[8*i +: 8] = 8'(k) ^ exp_seq[7:0];
          end
        end
        e_last = (off + 8 >= int'(exp_len));
        check("beat_data", m_if.data, e_data);
        check("beat_keep", 64'(m_if.keep), 64'(e_keep));
        check("beat_last", 64'(m_if.last), 64'(e_last));
        check("beat_user", 64'(m_if.user), (e_last && exp_err) ? 64'hFF : 64'h0);
        check("beat_id", 64'(m_if.id), 64'(exp_id));
        if (m_if.last) begin
          exp_seq++;
          frames_rx++;
          off       = 0;
          in_frame  = 1'b0;
          have_prev = 1'b1;
          idle_run  = 0;
        end else begin
          off += 8;
        end
      end
      held = m_if.valid && !m_if.ready;
      held_data = m_if.data;
      held_keep = m_if.keep;
      held_last = m_if.last;
      held_user = m_if.user;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [15:0] len, input logic [31:0] cnt, input logic [7:0] gap,
                             input logic [2:0] id, input logic err);
    cfg_len   = len;
    cfg_count = cnt;
    cfg_gap   = gap;
    cfg_id    = id;
    cfg_err   = err;
    start     = 1'b1;
    step();
    start     = 1'b0;
    check("first_valid", 64'(m_if.valid), 64'd1);
    check("busy_set", 64'(busy), 64'd1);
  endtask

  // Steps until done; checks done follows a last-beat handshake. n = cycles taken.
  task automatic wait_done(input int budget, input bit rnd, output int n);
    bit seen;
    bit prev_last;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < budget) begin
      if (rnd) m_if.ready = 1'($urandom_range(0, 1));
      prev_last = m_if.valid && m_if.ready && m_if.last;
      step();
      n++;
      if (done) begin
        seen = 1'b1;
        check("done_after_last", 64'(prev_last), 64'd1);
        check("busy_clear", 64'(busy), 64'd0);
      end
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    m_if.ready = 1'b1;
  endtask

  initial begin
    int n;
    reset_n    = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    cfg_len    = '0;
    cfg_count  = '0;
    cfg_gap    = '0;
    cfg_id     = '0;
    cfg_err    = 1'b0;
    m_if.ready = 1'b1;
    repeat (3) step();
    check("rst_valid", 64'(m_if.valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_frames", 64'(frames_sent), 64'd0);
    reset_n = 1'b1;
    step();

    // T1: two 64-byte frames back-to-back
    start_burst(16'd64, 32'd2, 8'd0, 3'd5, 1'b0);
    check("t1_first_beat", m_if.data, 64'h5AA5_0040_0000_0000);
    wait_done(100, 1'b0, n);
    check("t1_cycles", 64'(n), 64'd16);
    check("t1_frames_sent", 64'(frames_sent), 64'd2);
    check("t1_frames_rx", 64'(frames_rx), 64'd2);
    step();
    check("t1_done_pulse", 64'(done), 64'd0);
    check("t1_frames_hold", 64'(frames_sent), 64'd2);

    // T2: 61-byte frame, then 10 bytes clamped up to 60
    start_burst(16'd61, 32'd1, 8'd0, 3'd1, 1'b0);
    repeat (7) step();
    check("t2_keep61", 64'(m_if.keep), 64'h1F);
    check("t2_last61", 64'(m_if.last), 64'd1);
    check("t2_data61", m_if.data, 64'h0000_003C_3B3A_3938);
    wait_done(10, 1'b0, n);
    check("t2_cycles61", 64'(n), 64'd1);
    check("t2_frames61", 64'(frames_sent), 64'd1);
    step();
    start_burst(16'd10, 32'd1, 8'd0, 3'd1, 1'b0);
    check("t2_first60", m_if.data, 64'h5AA5_003C_0000_0000);
    repeat (7) step();
    check("t2_keep60", 64'(m_if.keep), 64'h0F);
    check("t2_data60", m_if.data, 64'h0000_0000_3B3A_3938);
    wait_done(10, 1'b0, n);
    check("t2_frames_rx60", 64'(frames_rx), 64'd1);
    step();

    // T3: random ready over 20 frames of 100 bytes
    start_burst(16'd100, 32'd20, 8'd0, 3'd2, 1'b0);
    wait_done(3000, 1'b1, n);
    check("t3_frames_sent", 64'(frames_sent), 64'd20);
    check("t3_frames_rx", 64'(frames_rx), 64'd20);
    check("t3_seq_end", 64'(exp_seq), 64'd20);
    step();

    // T4: endless burst, gap 3, ignored restart, stop inside the 5th frame
    start_burst(16'd60, 32'd0, 8'd3, 3'd6, 1'b0);
    cfg_len = 16'd200;
    repeat (20) step();
    cfg_count = 32'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t4_busy_kept", 64'(busy), 64'd1);
    n = 0;
    while (!(frames_rx == 4 && m_if.valid) && n < 200) begin
      step();
      n++;
    end
    check("t4_reach_5th", 64'(frames_rx), 64'd4);
    repeat (2) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_done(50, 1'b0, n);
    check("t4_frames_sent", 64'(frames_sent), 64'd5);
    check("t4_frames_rx", 64'(frames_rx), 64'd5);
    check("t4_gap_min", 64'(gap_min), 64'd3);
    check("t4_gap_max", 64'(gap_max), 64'd3);
    repeat (3) step();
    check("t4_idle_valid", 64'(m_if.valid), 64'd0);
    check("t4_frames_hold", 64'(frames_sent), 64'd5);

    // T5: reset mid-frame, then restart with error marking
    start_burst(16'd100, 32'd3, 8'd0, 3'd3, 1'b1);
    n = 0;
    while (frames_rx != 1 && n < 100) begin
      step();
      n++;
    end
    repeat (3) step();
    check("t5_pre_frames", 64'(frames_sent), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(m_if.valid), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_frames", 64'(frames_sent), 64'd0);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    start_burst(16'd64, 32'd1, 8'd0, 3'd4, 1'b1);
    check("t5_seq0", m_if.data, 64'h5AA5_0040_0000_0000);
    check("t5_user_first", 64'(m_if.user), 64'h0);
    repeat (7) step();
    check("t5_user_last", 64'(m_if.user), 64'hFF);
    check("t5_last", 64'(m_if.last), 64'd1);
    wait_done(10, 1'b0, n);
    check("t5_frames_sent", 64'(frames_sent), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
